// File: rtl/voice_addr_sched.sv
// Time-multiplexed sample-address scheduler: each tick scans all voices in a
// fixed order and issues one ROM address per active voice.
module voice_addr_sched #(
    parameter int NV = 4,
    parameter int AW = 16,
    parameter int IW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic [NV-1:0]   trig,
    input  logic [NV-1:0]   stop,
    input  logic [NV-1:0]   loop_en,
    input  logic [NV*AW-1:0] first_bus,
    input  logic [NV*AW-1:0] last_bus,
    output logic [AW-1:0]   rom_addr,
    output logic            rom_valid,
    output logic [IW-1:0]   voice_id,
    output logic [NV-1:0]   active,
    output logic            frame_done,
    output logic            overrun
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NV - 1);

    state_t                 state;
    logic [IW-1:0]          idx;
    logic [NV-1:0][AW-1:0]  ptr;
    logic [NV-1:0][AW-1:0]  first_v;
    logic [NV-1:0][AW-1:0]  last_v;

    assign first_v = first_bus;
    assign last_v  = last_bus;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            ptr        <= '0;
            active     <= '0;
            rom_addr   <= '0;
            rom_valid  <= 1'b0;
            voice_id   <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rom_valid  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= SCAN;
                        idx   <= '0;
                    end
                end
                SCAN: begin
                    if (tick)
                        overrun <= 1'b1;
                    if (active[idx]) begin
                        rom_addr  <= ptr[idx];
                        voice_id  <= idx;
                        rom_valid <= 1'b1;
                        if (ptr[idx] != last_v[idx])
                            ptr[idx] <= ptr[idx] + AW'(1);
                        else if (loop_en[idx])
                            ptr[idx] <= first_v[idx];
                        else
                            active[idx] <= 1'b0;
                    end
                    if (idx == LAST_IDX) begin
                        state      <= IDLE;
                        idx        <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            // Front-end commands land after the service update so they override
            // it; stop is applied last so it beats a simultaneous trig.
            for (int i = 0; i < NV; i++) begin
                if (trig[i]) begin
                    ptr[i]    <= first_v[i];
                    active[i] <= 1'b1;
                end
                if (stop[i])
                    active[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_voice_addr_sched.sv
// Bench for voice_addr_sched: directed scenarios plus randomized scans
// against a per-voice playback model.
module tb_voice_addr_sched;
    localparam int NV = 4;
    localparam int AW = 16;
    localparam int IW = 2;

    logic            clk = 0;
    logic            rst = 0;
    logic            tick = 0;
    logic [NV-1:0]   trig = '0;
    logic [NV-1:0]   stop = '0;
    logic [NV-1:0]   loop_en = '0;
    logic [NV*AW-1:0] first_bus = '0;
    logic [NV*AW-1:0] last_bus = '0;
    logic [AW-1:0]   rom_addr;
    logic            rom_valid;
    logic [IW-1:0]   voice_id;
    logic [NV-1:0]   active;
    logic            frame_done;
    logic            overrun;

    voice_addr_sched #(.NV(NV), .AW(AW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .tick(tick), .trig(trig), .stop(stop),
        .loop_en(loop_en), .first_bus(first_bus), .last_bus(last_bus),
        .rom_addr(rom_addr), .rom_valid(rom_valid), .voice_id(voice_id),
        .active(active), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // outputs after scan edge E1..ENV
    logic          cap_v  [1:NV];
    logic [AW-1:0] cap_a  [1:NV];
    logic [IW-1:0] cap_id [1:NV];
    logic          cap_fd [1:NV];

    // reference model state
    logic [AW-1:0] mf [NV];
    logic [AW-1:0] ml [NV];
    logic          mle[NV];
    logic [AW-1:0] mptr[NV];
    logic          mact[NV];

    task automatic do_reset();
        rst = 1; trig = '0; stop = '0; tick = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic set_voice(input int i, input logic [AW-1:0] f, input logic [AW-1:0] l,
                             input logic le);
        first_bus[i*AW +: AW] = f;
        last_bus[i*AW +: AW]  = l;
        loop_en[i]            = le;
    endtask

    task automatic pulse(input logic [NV-1:0] t, input logic [NV-1:0] s);
        trig = t; stop = s;
        @(negedge clk);
        trig = '0; stop = '0;
    endtask

    // tick sampled at E0; optional extra tick held for scan edge tick_at
    task automatic run_scan(input int tick_at);
        tick = 1;
        @(negedge clk);
        for (int c = 1; c <= NV; c++) begin
            tick = (c == tick_at);
            @(negedge clk);
            cap_v[c] = rom_valid; cap_a[c] = rom_addr;
            cap_id[c] = voice_id; cap_fd[c] = frame_done;
        end
        tick = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        @(negedge clk); @(negedge clk);
        tests++;
        if (rom_valid !== 1'b0 || rom_addr !== '0 || voice_id !== '0 || active !== '0 ||
            frame_done !== 1'b0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL reset: valid=%b addr=%h id=%0d act=%b fd=%b ovr=%b, want all 0",
                     rom_valid, rom_addr, voice_id, active, frame_done, overrun);
        end
        rst = 0;
    endtask

    task automatic test_single_loop();
        logic [AW-1:0] exp [5];
        exp = '{16'h0010, 16'h0011, 16'h0012, 16'h0010, 16'h0011};
        do_reset();
        set_voice(0, 16'h0010, 16'h0012, 1'b1);
        pulse(4'b0001, 4'b0000);
        for (int s = 0; s < 5; s++) begin
            run_scan(0);
            tests++;
            if (cap_v[1] !== 1'b1 || cap_a[1] !== exp[s] || cap_id[1] !== 2'd0) begin
                fails++;
                $display("FAIL loop s%0d: valid=%b addr=%h id=%0d, want 1 %h 0",
                         s, cap_v[1], cap_a[1], cap_id[1], exp[s]);
            end
            tests++;
            if (cap_v[2] !== 1'b0 || cap_v[3] !== 1'b0 || cap_v[4] !== 1'b0 ||
                cap_fd[4] !== 1'b1 || cap_fd[1] !== 1'b0) begin
                fails++;
                $display("FAIL loop_slots s%0d: v2..4=%b%b%b fd1=%b fd4=%b, want 000 0 1",
                         s, cap_v[2], cap_v[3], cap_v[4], cap_fd[1], cap_fd[4]);
            end
        end
    endtask

    task automatic test_one_shot();
        do_reset();
        set_voice(1, 16'h0100, 16'h0101, 1'b0);
        pulse(4'b0010, 4'b0000);
        for (int s = 0; s < 3; s++) begin
            run_scan(0);
            tests++;
            if (s < 2) begin
                if (cap_v[2] !== 1'b1 || cap_a[2] !== 16'h0100 + AW'(s) || cap_id[2] !== 2'd1) begin
                    fails++;
                    $display("FAIL oneshot s%0d: valid=%b addr=%h id=%0d, want 1 %h 1",
                             s, cap_v[2], cap_a[2], cap_id[2], 16'h0100 + AW'(s));
                end
            end else if (cap_v[2] !== 1'b0) begin
                fails++;
                $display("FAIL oneshot_end: valid=%b, want 0", cap_v[2]);
            end
            tests++;
            if (cap_fd[4] !== 1'b1) begin
                fails++;
                $display("FAIL oneshot_fd s%0d: fd=%b, want 1", s, cap_fd[4]);
            end
        end
        tests++;
        if (active[1] !== 1'b0) begin
            fails++;
            $display("FAIL oneshot_active: active=%b, want bit1 0", active);
        end
    endtask

    task automatic test_multi_order();
        do_reset();
        set_voice(0, 16'h0000, 16'h000F, 1'b1);
        set_voice(2, 16'h0200, 16'h020F, 1'b1);
        set_voice(3, 16'h0300, 16'h030F, 1'b1);
        pulse(4'b1101, 4'b0000);
        run_scan(0);
        tests++;
        if (cap_v[1] !== 1 || cap_id[1] !== 2'd0 || cap_a[1] !== 16'h0000 ||
            cap_v[2] !== 0 ||
            cap_v[3] !== 1 || cap_id[3] !== 2'd2 || cap_a[3] !== 16'h0200 ||
            cap_v[4] !== 1 || cap_id[4] !== 2'd3 || cap_a[4] !== 16'h0300) begin
            fails++;
            $display("FAIL multi: v=%b%b%b%b id=%0d,%0d,%0d a=%h,%h,%h, want 1011 0,2,3 0000,0200,0300",
                     cap_v[1], cap_v[2], cap_v[3], cap_v[4], cap_id[1], cap_id[3], cap_id[4],
                     cap_a[1], cap_a[3], cap_a[4]);
        end
        tests++;
        if (cap_fd[3] !== 1'b0 || cap_fd[4] !== 1'b1) begin
            fails++;
            $display("FAIL multi_fd: fd3=%b fd4=%b, want 0 1", cap_fd[3], cap_fd[4]);
        end
    endtask

    task automatic test_collisions();
        do_reset();
        set_voice(2, 16'h0200, 16'h020F, 1'b1);
        pulse(4'b0100, 4'b0000);
        tests++;
        if (active[2] !== 1'b1) begin
            fails++;
            $display("FAIL trig_alone: active=%b, want bit2 1", active);
        end
        pulse(4'b0100, 4'b0100);
        tests++;
        if (active[2] !== 1'b0) begin
            fails++;
            $display("FAIL trig_stop: active=%b, want bit2 0", active);
        end
        set_voice(0, 16'h0040, 16'h004F, 1'b1);
        pulse(4'b0001, 4'b0000);
        run_scan(0);
        // retrigger voice 0 exactly at its service edge E1
        tick = 1;
        @(negedge clk);
        tick = 0; trig = 4'b0001;
        @(negedge clk);
        trig = '0;
        tests++;
        if (rom_valid !== 1'b1 || rom_addr !== 16'h0041) begin
            fails++;
            $display("FAIL trig_service: valid=%b addr=%h, want 1 0041", rom_valid, rom_addr);
        end
        repeat (NV - 1) @(negedge clk);
        run_scan(0);
        tests++;
        if (cap_v[1] !== 1'b1 || cap_a[1] !== 16'h0040) begin
            fails++;
            $display("FAIL trig_restart: valid=%b addr=%h, want 1 0040", cap_v[1], cap_a[1]);
        end
    endtask

    task automatic test_overrun_wrap();
        logic [AW-1:0] exp [5];
        exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFE};
        do_reset();
        set_voice(3, 16'hFFFE, 16'h0001, 1'b1);
        pulse(4'b1000, 4'b0000);
        for (int s = 0; s < 5; s++) begin
            run_scan(s == 0 ? 2 : 0);
            tests++;
            if (cap_v[4] !== 1'b1 || cap_a[4] !== exp[s] || cap_id[4] !== 2'd3 || cap_fd[4] !== 1'b1) begin
                fails++;
                $display("FAIL wrap s%0d: valid=%b addr=%h id=%0d fd=%b, want 1 %h 3 1",
                         s, cap_v[4], cap_a[4], cap_id[4], cap_fd[4], exp[s]);
            end
            if (s == 0) begin
                tests++;
                if (overrun !== 1'b1) begin
                    fails++;
                    $display("FAIL overrun_set: overrun=%b, want 1", overrun);
                end
                // dropped tick must not start another scan
                for (int c = 0; c < NV + 1; c++) begin
                    @(negedge clk);
                    tests++;
                    if (rom_valid !== 1'b0 || frame_done !== 1'b0) begin
                        fails++;
                        $display("FAIL no_extra_scan c%0d: valid=%b fd=%b, want 0 0",
                                 c, rom_valid, frame_done);
                    end
                end
            end
        end
        tests++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_sticky: overrun=%b, want 1", overrun);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_voice(0, 16'h0000, 16'h00FF, 1'b1);
        set_voice(1, 16'h1000, 16'h10FF, 1'b1);
        set_voice(2, 16'h2000, 16'h20FF, 1'b1);
        set_voice(3, 16'h3000, 16'h30FF, 1'b1);
        pulse(4'b1111, 4'b0000);
        run_scan(1);
        tick = 1;
        @(negedge clk);
        tick = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        tests++;
        if (rom_valid !== 1'b0 || active !== '0 || overrun !== 1'b0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: valid=%b act=%b ovr=%b fd=%b, want 0 0000 0 0",
                     rom_valid, active, overrun, frame_done);
        end
        run_scan(0);
        tests++;
        if (cap_v[1] !== 0 || cap_v[2] !== 0 || cap_v[3] !== 0 || cap_v[4] !== 0) begin
            fails++;
            $display("FAIL reset_mid_scan: v=%b%b%b%b, want 0000",
                     cap_v[1], cap_v[2], cap_v[3], cap_v[4]);
        end
    endtask

    task automatic test_random();
        logic [NV-1:0] t, s, exp_act;
        do_reset();
        for (int i = 0; i < NV; i++) begin
            mf[i] = '0; ml[i] = '0; mle[i] = 0; mptr[i] = '0; mact[i] = 0;
            set_voice(i, '0, '0, 1'b0);
        end
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NV; i++)
                if ($urandom_range(0, 3) == 0) begin
                    mf[i]  = AW'($urandom);
                    ml[i]  = mf[i] + AW'($urandom_range(0, 5));
                    mle[i] = 1'($urandom_range(0, 1));
                    set_voice(i, mf[i], ml[i], mle[i]);
                end
            t = NV'($urandom) & NV'($urandom);
            s = NV'($urandom) & NV'($urandom) & NV'($urandom);
            for (int i = 0; i < NV; i++) begin
                if (t[i]) begin mptr[i] = mf[i]; mact[i] = 1; end
                if (s[i]) mact[i] = 0;
            end
            pulse(t, s);
            run_scan(0);
            for (int k = 0; k < NV; k++) begin
                tests++;
                if (cap_v[k+1] !== mact[k] ||
                    (mact[k] && (cap_a[k+1] !== mptr[k] || cap_id[k+1] !== IW'(k)))) begin
                    fails++;
                    $display("FAIL rand it%0d v%0d: valid=%b addr=%h id=%0d, want %b %h %0d",
                             it, k, cap_v[k+1], cap_a[k+1], cap_id[k+1], mact[k], mptr[k], k);
                end
                if (mact[k]) begin
                    if (mptr[k] == ml[k]) begin
                        if (mle[k]) mptr[k] = mf[k];
                        else mact[k] = 0;
                    end else begin
                        mptr[k] = mptr[k] + 1'b1;
                    end
                end
            end
            for (int k = 0; k < NV; k++) exp_act[k] = mact[k];
            tests++;
            if (active !== exp_act) begin
                fails++;
                $display("FAIL rand_active it%0d: active=%b, want %b", it, active, exp_act);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_loop();
        test_one_shot();
        test_multi_order();
        test_collisions();
        test_overrun_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/voice_addr_sched.md
Name: voice_addr_sched

Overview:
- Time-multiplexed sample-address scheduler. One sample ROM address port is shared among NV synthesizer voices.
- Each voice holds its own playback pointer that runs from a configured first address to a configured last address, then loops or stops.
- On every sample-rate tick the block scans all voices in fixed order. It issues one ROM address per active voice and advances that voice's pointer.
- It sits between the key/note front end (trigger/stop, region select) and the sample ROM plus mixer.

Parameters:
- NV, 4, number of voices (2..16)
- AW, 16, ROM address width
- IW, 2, voice index width, equal to ceil(log2(NV))

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  sample-rate strobe, one cycle wide
- trig  in  NV  per-voice start pulse
- stop  in  NV  per-voice stop pulse
- loop_en  in  NV  per-voice loop mode; 1 = wrap to first, 0 = one-shot
- first_bus  in  NV*AW  per-voice first address; voice i uses bits [i*AW +: AW]
- last_bus  in  NV*AW  per-voice last address; same packing as first_bus
- rom_addr  out  AW  registered ROM address
- rom_valid  out  1  rom_addr/voice_id valid this cycle
- voice_id  out  IW  voice that owns rom_addr
- active  out  NV  per-voice playing flag
- frame_done  out  1  one-cycle pulse at the end of each scan
- overrun  out  1  sticky flag; a tick arrived during a scan

Behaviour:
- Reset (sync, rst=1 at an edge):
  - state=IDLE, idx=0.
  - All pointers are 0 and active=0.
  - rom_addr=0, rom_valid=0, voice_id=0, frame_done=0, overrun=0.
  - rst overrides every other input, including mid-scan. A scan in progress is abandoned with no further rom_valid.
- FSM has two states, IDLE and SCAN.
  - IDLE: tick=1 at edge E0 → state=SCAN, idx=0.
  - SCAN: each edge processes voice idx, then idx increments.
  - At the edge that processes idx=NV-1: state=IDLE, frame_done=1 for exactly the following cycle.
- Voice service, at the edge processing idx=k:
  - If active[k]=1: rom_addr<=ptr[k], voice_id<=k, rom_valid<=1.
  - Otherwise rom_valid<=0 and rom_addr/voice_id hold.
- Pointer update for a serviced voice:
  - ptr[k]!=last[k]: ptr[k]<=ptr[k]+1, modulo 2^AW.
  - ptr[k]==last[k] and loop_en[k]=1: ptr[k]<=first[k].
  - ptr[k]==last[k] and loop_en[k]=0: active[k]<=0. The last address is still issued this scan.
- Latency: tick sampled at E0 → voice k's address is visible after edge E(1+k). A full scan always takes NV cycles, regardless of how many voices are active.
- Trigger and stop, sampled every cycle in any state:
  - trig[i]: ptr[i]<=first[i], active[i]<=1.
  - stop[i]: active[i]<=0, ptr[i] unchanged.
  - trig[i] and stop[i] in the same cycle: stop wins.
  - trig/stop on voice i in the same cycle that voice i is serviced: the address already selected is still issued, then the trig/stop result overrides the pointer/active update.
- Equal limits: first==last gives a one-address region. In loop mode the same address is issued every tick.
- first>last: the pointer counts up through 2^AW-1, wraps to 0, and continues until it equals last. Plain modulo arithmetic; no error is flagged.
- Overrun: tick=1 while state==SCAN (including the final scan cycle) is dropped and sets overrun=1. overrun is cleared only by rst.
- first_bus/last_bus/loop_en are sampled live at the edge where they are used. Changing them mid-play affects the next compare or wrap.

Test Plan:
1. Single-voice loop: rst; voice0 first=0x0010, last=0x0012, loop_en=1; trig[0]; 5 ticks spaced ≥NV+1 cycles apart → rom_addr sequence 0x10,0x11,0x12,0x10,0x11, each with voice_id=0 and rom_valid high for 1 cycle, appearing 1 cycle after the tick edge.
2. One-shot end: voice1 first=0x0100, last=0x0101, loop_en=0; trig[1]; 3 ticks → addresses 0x100,0x101, then active[1]=0 and no rom_valid for voice 1 on the third tick; frame_done still pulses every tick.
3. Multi-voice order: voices 0,2,3 active with first values 0x0,0x200,0x300 → one tick yields rom_valid in cycles E1,E3,E4 with voice_id 0,2,3; cycle E2 has rom_valid=0; frame_done after E4.
4. Collisions: trig[2] and stop[2] in the same cycle → active[2]=0. trig[0] during voice 0's service cycle → current address issued, next tick issues first[0].
5. Overrun and wrap: tick asserted during the 2nd scan cycle → overrun=1, scan length unchanged, no extra scan. Voice first=0xFFFE, last=0x0001, loop → 0xFFFE,0xFFFF,0x0000,0x0001,0xFFFE.
6. Reset mid-scan: rst asserted at E2 of a scan → next cycle state=IDLE, active=0, rom_valid=0, overrun=0; the following tick produces no rom_valid.
